// File: rtl/cntr_sampler.sv
// cntr_sampler: synchronise and glitch-filter an asynchronous ripple count, accumulate
// modular deltas into a saturating total and publish it per period over valid/ready.
module cntr_sampler #(
    parameter int COUNT_WIDTH   = 4,
    parameter int ACC_WIDTH     = 16,
    parameter int STABLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [COUNT_WIDTH-1:0] count_in,
    input  logic                   period_tick,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [ACC_WIDTH-1:0]   out_total,
    output logic                   out_sat,
    output logic                   overrun,
    output logic [COUNT_WIDTH-1:0] stable_count
);
    localparam int RW = $clog2(STABLE_CYCLES + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] s1_q, s2_q, s2p_q, stable_q, stable_d, delta;
    logic [1:0]             prime_q, prime_d;
    logic [RW-1:0]          run_q, run_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d, total_q, total_d;
    logic [ACC_WIDTH:0]     sum;
    logic                   sat_q, sat_d, osat_q, osat_d, valid_q, valid_d, overrun_q, overrun_d;
    logic                   eq, accept, add, publish;

    // Comparisons are ignored until the sync chain holds real samples, so the reset
    // zeros are never mistaken for a stable counter value.
    always_comb begin
        prime_d  = (prime_q == 2'd3) ? prime_q : prime_q + 2'd1;
        eq       = (prime_q == 2'd3) && (s2_q == s2p_q);
        run_d    = !eq ? '0 : (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
        accept   = eq && (run_d == RUN_MAX) &&
                   (run_q != RUN_MAX || s2_q != stable_q || state_q == IDLE);
        stable_d = accept ? s2_q : stable_q;
        delta    = s2_q - stable_q;
    end

    always_comb begin
        state_d = (state_q == IDLE) ? (accept ? RUN : IDLE)
                : (state_q == RUN)  ? (period_tick ? HOLD : RUN)
                : (out_ready && !period_tick) ? RUN : HOLD;
    end

    always_comb begin
        add       = accept && en && (state_q != IDLE);
        sum       = {1'b0, acc_q} + (ACC_WIDTH + 1)'(delta);
        publish   = period_tick && (state_q == RUN || (state_q == HOLD && out_ready));
        acc_d     = publish ? (add ? ACC_WIDTH'(delta) : '0)
                  : !add    ? acc_q
                  : sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
        sat_d     = publish ? 1'b0 : (sat_q | (add & sum[ACC_WIDTH]));
        total_d   = publish ? acc_q : total_q;
        osat_d    = publish ? sat_q : osat_q;
        valid_d   = (state_d == HOLD);
        overrun_d = period_tick && (state_q == HOLD) && !out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            s1_q      <= '0;
            s2_q      <= '0;
            s2p_q     <= '0;
            prime_q   <= '0;
            run_q     <= '0;
            stable_q  <= '0;
            acc_q     <= '0;
            sat_q     <= 1'b0;
            total_q   <= '0;
            osat_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_q      <= count_in;
            s2_q      <= s1_q;
            s2p_q     <= s2_q;
            prime_q   <= prime_d;
            run_q     <= run_d;
            stable_q  <= stable_d;
            acc_q     <= acc_d;
            sat_q     <= sat_d;
            total_q   <= total_d;
            osat_q    <= osat_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_total    = total_q;
    assign out_sat      = osat_q;
    assign overrun      = overrun_q;
    assign stable_count = stable_q;
endmodule
